// File: rtl/ram_programmer.sv
// Front-panel program loader: owns the CPU RAM while the program switch is set,
// writes each host byte, reads it back to check it, then returns the RAM with a restart pulse.
module ram_programmer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prog_mode_i,
    input  logic              host_valid_i,
    input  logic [DATA_W-1:0] host_data_i,
    input  logic              host_last_i,
    output logic              host_ready_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              bus_own_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_we_o,
    output logic              cpu_hold_o,
    output logic              cpu_restart_o,
    output logic              prog_done_o,
    output logic              prog_err_o,
    output logic [ADDR_W:0]   bytes_written_o,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_LOAD    = 3'd2,
        S_WRITE   = 3'd3,
        S_VERIFY  = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6,
        S_RELEASE = 3'd7
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t              state_q, state_d;
    logic                sync1_q, psync_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     count_q, count_d;

    // Two-flop synchronizer for the asynchronous program switch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            psync_q <= 1'b0;
        end else begin
            sync1_q <= prog_mode_i;
            psync_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        last_d        = last_q;
        done_d        = done_q;
        err_d         = err_q;
        count_d       = count_q;
        host_ready_o  = 1'b0;
        bus_own_o     = 1'b0;
        cpu_hold_o    = 1'b0;
        ram_we_o      = 1'b0;
        cpu_restart_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (psync_q) state_d = S_ARM;
            end
            S_ARM: begin
                bus_own_o  = 1'b1;
                cpu_hold_o = 1'b1;
                addr_d     = '0;
                count_d    = '0;
                done_d     = 1'b0;
                err_d      = 1'b0;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                bus_own_o    = 1'b1;
                cpu_hold_o   = 1'b1;
                // Not ready in the abort cycle, so the host never loses a byte.
                host_ready_o = psync_q;
                if (!psync_q) begin
                    state_d = S_RELEASE;
                end else if (host_valid_i) begin
                    wdata_d = host_data_i;
                    last_d  = host_last_i;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                bus_own_o  = 1'b1;
                cpu_hold_o = 1'b1;
                ram_we_o   = 1'b1;
                state_d    = psync_q ? S_VERIFY : S_RELEASE;
            end
            S_VERIFY: begin
                bus_own_o  = 1'b1;
                cpu_hold_o = 1'b1;
                if (!psync_q) begin
                    state_d = S_RELEASE;
                end else if (ram_rdata_i != wdata_q) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    count_d = count_q + 1'b1;
                    if (last_q || addr_q == ADDR_MAX) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                bus_own_o  = 1'b1;
                cpu_hold_o = 1'b1;
                if (!psync_q) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                cpu_restart_o = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address and data reach the RAM muxes only while this block owns the bus.
    assign ram_addr_o      = bus_own_o ? addr_q : '0;
    assign ram_wdata_o     = bus_own_o ? wdata_q : '0;
    assign prog_done_o     = done_q;
    assign prog_err_o      = err_q;
    assign bytes_written_o = count_q;
    assign dbg_state_o     = state_q;

endmodule

// File: doc/ram_programmer.md
# ram_programmer

Loads a program into the 16-byte RAM of the 8-bit CPU from a byte-wide host port while the front-panel program switch is set. It takes the RAM away from the CPU, holds the CPU, writes each host byte, reads it back to check it, and then hands the RAM back to the CPU with a restart pulse. It sits between the host/loader interface, the RAM address/data muxes and the CPU control path (the microcode decoder and the program counter).

## Interface
- ADDR_W, 4, RAM address width; the RAM depth is 2^ADDR_W.
- DATA_W, 8, width of the data bus and the host byte.

- clk  in  1  system clock; every flop updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- prog_mode  in  1  program switch; asynchronous to clk, synchronized inside the block.
- host_valid  in  1  host_data is valid this cycle.
- host_data  in  DATA_W  byte to write to RAM.
- host_last  in  1  qualifies host_data; marks the final byte of the program.
- host_ready  out  1  the block accepts a byte this cycle.
- ram_rdata  in  DATA_W  RAM output, asynchronous read of ram_addr.
- bus_own  out  1  1 means the RAM address/data muxes select this block and not the CPU.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write strobe, one cycle per byte.
- cpu_hold  out  1  holds the decoder and program counter still.
- cpu_restart  out  1  one-cycle pulse that clears the program counter and the microstep counter.
- prog_done  out  1  programming completed without error.
- prog_err  out  1  read-back mismatch (sticky).
- bytes_written  out  ADDR_W+1  number of bytes written and verified in this session.

## Operation
- prog_mode passes through a 2-flop synchronizer. The block acts only on the synchronized signal, psync.
- States and what each does:
  - IDLE: all outputs 0 except the held flags. When psync=1, go to ARM.
  - ARM: bus_own=1, cpu_hold=1. Clear addr, bytes_written, prog_done and prog_err. Go to LOAD.
  - LOAD: host_ready=1.
    - On host_valid=1, latch host_data into ram_wdata, latch host_last into last_q, and go to WRITE.
    - With no valid byte, stay in LOAD.
  - WRITE: ram_we=1, ram_addr=addr. Go to VERIFY.
  - VERIFY: ram_we=0, ram_addr=addr. Compare ram_rdata with ram_wdata.
    - Mismatch: set prog_err and go to ERROR.
    - Match: increment bytes_written.
      - If last_q=1 or addr=2^ADDR_W-1, set prog_done and go to DONE.
      - Otherwise increment addr and go to LOAD.
  - DONE / ERROR: host_ready=0, bus_own=1, cpu_hold=1. When psync=0, go to RELEASE.
  - RELEASE: cpu_restart=1, bus_own=0, cpu_hold=0. Go to IDLE.
- Abort: psync=0 in LOAD, WRITE or VERIFY sends the block to RELEASE on the next edge.
  - A write already strobed stays written but is not counted.
  - No flag is set.
- prog_done, prog_err and bytes_written keep their values through RELEASE and IDLE. They clear only in ARM or on rst.
- addr never wraps. A host byte offered after DONE is never accepted.
- In every state except LOAD, host_ready=0 and host_valid is ignored.

## Timing
- Reset: state=IDLE and addr=0. Every output is 0, including bytes_written=0.
- From a prog_mode rise to bus_own=1 takes 3 rising edges: 2 synchronizer edges plus the IDLE→ARM edge. host_ready=1 one cycle after that.
- Handshake: a byte transfers on a rising edge where host_valid && host_ready.
  - host_ready drops in the following cycle.
  - The host must hold host_data and host_last stable only during that cycle.
- Each byte costs 3 cycles (LOAD, WRITE, VERIFY), so peak throughput is 1 byte per 3 cycles.
- ram_we is high for exactly one cycle, the WRITE cycle. ram_addr is unchanged through WRITE and VERIFY.
- prog_done or prog_err asserts on the edge that leaves VERIFY.
- From a prog_mode fall to the cpu_restart pulse takes 3 edges. bus_own and cpu_hold fall in the same cycle as the pulse.
- If rst asserts mid-operation, the block returns immediately to the reset state with bus_own=0. cpu_restart is not pulsed.

## Test plan
- Load 3 bytes 0x1E, 0x2F, 0xE0 with host_last on 0xE0, RAM model correct, then release the switch:
  - ram_we pulses at addr 0, 1, 2.
  - prog_done=1 and bytes_written=3.
  - One cpu_restart pulse 3 cycles after the prog_mode fall, with bus_own=0 in the same cycle.
- Load 16 bytes with host_last never asserted: DONE after addr 15, bytes_written=16, and a 17th host_valid leaves host_ready=0.
- Corrupt the RAM model so addr 2 reads 0x00 where 0x55 was written: prog_err=1, bytes_written=2, and state stays ERROR until prog_mode falls.
- Drop prog_mode while the block waits in LOAD after 1 byte: cpu_restart pulses, prog_done=0, prog_err=0, bytes_written=1.
- Assert rst during WRITE: every output is 0 on that edge, and the next session starts cleanly at addr 0.
- Toggle host_valid randomly with gaps of 0-5 cycles: every transfer occurs only when host_ready=1, and RAM contents match the sequence that was sent.
